// File: rtl/hsv_pkg.sv
// Shared widths, constants and FSM state type for the hsv2rgb scheduling datapath.
package hsv_pkg;

   localparam int unsigned H_W   = 25;
   localparam int unsigned SV_W  = 18;
   localparam int unsigned RGB_W = 10;

   localparam logic [H_W-1:0]  HUE_360  = 25'h1680000;
   localparam logic [SV_W-1:0] ONE_2P16 = 18'h10000;

   typedef enum logic {IDLE, HOLD} state_e;

endpackage

// File: rtl/rr_burst_arb.sv
// Round-robin arbiter with burst hold: the owner keeps the grant for up to BURST
// consecutive accepts, then the others are searched first starting after the owner.
module rr_burst_arb
   import hsv_pkg::*;
#(
   parameter int unsigned N_REQ = 4,
   parameter int unsigned IDW   = 2,
   parameter int unsigned BURST = 4
) (
   input  logic                         i_clk,
   input  logic                         i_rst_n,
   input  logic [N_REQ-1:0]             i_valid,
   input  logic                         i_accept,
   output logic [N_REQ-1:0]             o_grant,
   output logic [IDW-1:0]               o_gnt_id,
   output logic [IDW-1:0]               o_owner,
   output logic [IDW-1:0]               o_ptr,
   output logic [$clog2(BURST+1)-1:0]   o_cnt
);

   localparam int unsigned CNT_W = $clog2(BURST + 1);

   state_e             r_state, w_state_d;
   logic [IDW-1:0]     r_owner, w_owner_d;
   logic [IDW-1:0]     r_ptr, w_ptr_d;
   logic [CNT_W-1:0]   r_cnt, w_cnt_d;

   logic [IDW-1:0]     w_owner_inc;
   logic [IDW-1:0]     w_base;
   logic               w_rearb;
   logic               w_found;
   logic [IDW-1:0]     w_pick;
   int unsigned        w_idx;

   assign w_owner_inc = (r_owner == IDW'(N_REQ - 1)) ? '0 : r_owner + IDW'(1);
   assign w_rearb     = (r_state == HOLD) &&
                        (!i_valid[r_owner] || (r_cnt == CNT_W'(BURST)));
   assign w_base      = (r_state == IDLE) ? r_ptr : w_owner_inc;

   // Scanning N_REQ slots from owner+1 visits the owner last, giving others priority.
   always_comb begin
      w_found = 1'b0;
      w_pick  = '0;
      w_idx   = 0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         w_idx = int'(w_base) + i;
         if (w_idx >= N_REQ) w_idx = w_idx - N_REQ;
         if (!w_found && i_valid[IDW'(w_idx)]) begin
            w_found = 1'b1;
            w_pick  = IDW'(w_idx);
         end
      end
   end

   always_comb begin
      w_state_d = r_state;
      w_owner_d = r_owner;
      w_ptr_d   = r_ptr;
      w_cnt_d   = r_cnt;
      o_grant   = '0;
      o_gnt_id  = r_owner;
      unique case (r_state)
         IDLE: begin
            if (w_found) begin
               o_grant   = N_REQ'(1) << w_pick;
               o_gnt_id  = w_pick;
               w_state_d = HOLD;
               w_owner_d = w_pick;
               w_cnt_d   = CNT_W'(1);
            end
         end
         HOLD: begin
            if (!w_rearb) begin
               o_grant[r_owner] = 1'b1;
               if (i_accept) w_cnt_d = r_cnt + CNT_W'(1);
            end else begin
               w_ptr_d = w_owner_inc;
               if (w_found) begin
                  o_grant   = N_REQ'(1) << w_pick;
                  o_gnt_id  = w_pick;
                  w_owner_d = w_pick;
                  w_cnt_d   = CNT_W'(1);
               end else begin
                  w_state_d = IDLE;
                  w_cnt_d   = '0;
               end
            end
         end
         default: w_state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= IDLE;
         r_owner <= '0;
         r_ptr   <= '0;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_d;
         r_owner <= w_owner_d;
         r_ptr   <= w_ptr_d;
         r_cnt   <= w_cnt_d;
      end
   end

   assign o_owner = r_owner;
   assign o_ptr   = r_ptr;
   assign o_cnt   = r_cnt;

endmodule

// File: rtl/hsv2rgb_sched.sv
// Shares one fixed-latency hsv2rgb converter among N_REQ requesters; a tag pipeline
// matched to the converter latency returns each result with its requester ID.
module hsv2rgb_sched
   import hsv_pkg::*;
#(
   parameter int unsigned N_REQ    = 4,
   parameter int unsigned IDW      = 2,
   parameter int unsigned PIPE_LAT = 10,
   parameter int unsigned BURST    = 4
) (
   input  logic                    CLK,
   input  logic                    RST_N,
   input  logic [N_REQ-1:0]        req_valid,
   output logic [N_REQ-1:0]        req_ready,
   input  logic [H_W*N_REQ-1:0]    req_h,
   input  logic [SV_W*N_REQ-1:0]   req_s,
   input  logic [SV_W*N_REQ-1:0]   req_v,
   output logic [H_W-1:0]          cnv_h,
   output logic [SV_W-1:0]         cnv_s,
   output logic [SV_W-1:0]         cnv_v,
   input  logic [RGB_W-1:0]        cnv_r,
   input  logic [RGB_W-1:0]        cnv_g,
   input  logic [RGB_W-1:0]        cnv_b,
   output logic                    rsp_valid,
   output logic [IDW-1:0]          rsp_id,
   output logic [RGB_W-1:0]        rsp_r,
   output logic [RGB_W-1:0]        rsp_g,
   output logic [RGB_W-1:0]        rsp_b,
   output logic                    busy
);

   localparam int unsigned CNT_W = $clog2(BURST + 1);

   logic [N_REQ-1:0]            w_grant;
   logic [IDW-1:0]              w_gnt_id;
   logic [IDW-1:0]              w_owner;
   logic [IDW-1:0]              w_ptr;
   logic [CNT_W-1:0]            w_cnt;
   logic                        w_acc;
   logic                        w_unused_arb;

   logic [H_W-1:0]              r_cnv_h;
   logic [SV_W-1:0]             r_cnv_s;
   logic [SV_W-1:0]             r_cnv_v;
   logic [PIPE_LAT:0]           r_tag_vld;
   logic [PIPE_LAT:0][IDW-1:0]  r_tag_id;
   logic                        r_rsp_valid;
   logic [IDW-1:0]              r_rsp_id;
   logic [RGB_W-1:0]            r_rsp_r, r_rsp_g, r_rsp_b;
   logic                        r_busy;

   rr_burst_arb #(
      .N_REQ (N_REQ),
      .IDW   (IDW),
      .BURST (BURST)
   ) u_arb (
      .i_clk    (CLK),
      .i_rst_n  (RST_N),
      .i_valid  (req_valid),
      .i_accept (w_acc),
      .o_grant  (w_grant),
      .o_gnt_id (w_gnt_id),
      .o_owner  (w_owner),
      .o_ptr    (w_ptr),
      .o_cnt    (w_cnt)
   );

   assign w_unused_arb = ^{w_owner, w_ptr, w_cnt};
   assign req_ready    = w_grant;
   assign w_acc        = |(req_valid & w_grant);

   // Idle cycles drive zeros so the converter always sees a defined hue sector.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_cnv_h <= '0;
         r_cnv_s <= '0;
         r_cnv_v <= '0;
      end else if (w_acc) begin
         r_cnv_h <= req_h[w_gnt_id*H_W +: H_W];
         r_cnv_s <= req_s[w_gnt_id*SV_W +: SV_W];
         r_cnv_v <= req_v[w_gnt_id*SV_W +: SV_W];
      end else begin
         r_cnv_h <= '0;
         r_cnv_s <= '0;
         r_cnv_v <= '0;
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_tag_vld <= '0;
         r_tag_id  <= '0;
      end else begin
         r_tag_vld <= {r_tag_vld[PIPE_LAT-1:0], w_acc};
         r_tag_id  <= {r_tag_id[PIPE_LAT-1:0], w_gnt_id};
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_rsp_valid <= 1'b0;
         r_rsp_id    <= '0;
         r_rsp_r     <= '0;
         r_rsp_g     <= '0;
         r_rsp_b     <= '0;
         r_busy      <= 1'b0;
      end else begin
         r_rsp_valid <= r_tag_vld[PIPE_LAT];
         if (r_tag_vld[PIPE_LAT]) begin
            r_rsp_id <= r_tag_id[PIPE_LAT];
            r_rsp_r  <= cnv_r;
            r_rsp_g  <= cnv_g;
            r_rsp_b  <= cnv_b;
         end
         r_busy <= (|r_tag_vld) | (|req_valid);
      end
   end

   assign cnv_h     = r_cnv_h;
   assign cnv_s     = r_cnv_s;
   assign cnv_v     = r_cnv_v;
   assign rsp_valid = r_rsp_valid;
   assign rsp_id    = r_rsp_id;
   assign rsp_r     = r_rsp_r;
   assign rsp_g     = r_rsp_g;
   assign rsp_b     = r_rsp_b;
   assign busy      = r_busy;

endmodule

// File: tb/tb_hsv2rgb_sched.sv
// Scoreboard bench for hsv2rgb_sched with a behavioural PIPE_LAT-stage converter attached.
module tb_hsv2rgb_sched;
   import hsv_pkg::*;

   localparam int unsigned N_REQ    = 4;
   localparam int unsigned IDW      = 2;
   localparam int unsigned PIPE_LAT = 10;
   localparam int unsigned BURST    = 4;

   logic                   CLK = 1'b0;
   logic                   RST_N = 1'b0;
   logic [N_REQ-1:0]       req_valid;
   logic [N_REQ-1:0]       req_ready;
   logic [H_W*N_REQ-1:0]   req_h;
   logic [SV_W*N_REQ-1:0]  req_s;
   logic [SV_W*N_REQ-1:0]  req_v;
   logic [H_W-1:0]         cnv_h;
   logic [SV_W-1:0]        cnv_s, cnv_v;
   logic [RGB_W-1:0]       cnv_r, cnv_g, cnv_b;
   logic                   rsp_valid;
   logic [IDW-1:0]         rsp_id;
   logic [RGB_W-1:0]       rsp_r, rsp_g, rsp_b;
   logic                   busy;

   typedef struct {
      int           id;
      logic [29:0]  rgb;
      int           due;
   } exp_t;

   exp_t              sb[$];
   int                exp_gnt[$];
   int                rem[N_REQ];
   logic [H_W-1:0]    dat_h[N_REQ];
   logic [SV_W-1:0]   dat_s[N_REQ];
   logic [SV_W-1:0]   dat_v[N_REQ];
   logic [29:0]       exp_rgb[N_REQ];
   logic [N_REQ-1:0]  acc_mask = '0;
   int                cyc = 0;
   int                total = 0;
   int                bad = 0;

   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   for (genvar gi = 0; gi < N_REQ; gi++) begin : g_pack
      assign req_h[gi*H_W +: H_W]   = dat_h[gi];
      assign req_s[gi*SV_W +: SV_W] = dat_s[gi];
      assign req_v[gi*SV_W +: SV_W] = dat_v[gi];
   end

   hsv2rgb_sched #(
      .N_REQ    (N_REQ),
      .IDW      (IDW),
      .PIPE_LAT (PIPE_LAT),
      .BURST    (BURST)
   ) dut (
      .CLK       (CLK),
      .RST_N     (RST_N),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_h     (req_h),
      .req_s     (req_s),
      .req_v     (req_v),
      .cnv_h     (cnv_h),
      .cnv_s     (cnv_s),
      .cnv_v     (cnv_v),
      .cnv_r     (cnv_r),
      .cnv_g     (cnv_g),
      .cnv_b     (cnv_b),
      .rsp_valid (rsp_valid),
      .rsp_id    (rsp_id),
      .rsp_r     (rsp_r),
      .rsp_g     (rsp_g),
      .rsp_b     (rsp_b),
      .busy      (busy)
   );

   // Integer-degree hsv2rgb; full scale output is V>>6 saturated at 10'h3FC.
   function automatic logic [29:0] cnv_model(logic [H_W-1:0] h, logic [SV_W-1:0] s,
                                             logic [SV_W-1:0] v);
      longint hue, c, m, x, sec, f, r, g, b;
      hue = longint'(h >> 16);
      if (hue >= 360) hue = 0;
      c   = (longint'(v) * longint'(s)) >> 16;
      m   = longint'(v) - c;
      sec = hue / 60;
      f   = hue % 60;
      x   = (sec % 2 == 0) ? (c * f) / 60 : (c * (60 - f)) / 60;
      r = 0; g = 0; b = 0;
      case (sec)
         0: begin r = c; g = x; end
         1: begin r = x; g = c; end
         2: begin g = c; b = x; end
         3: begin g = x; b = c; end
         4: begin r = x; b = c; end
         default: begin r = c; b = x; end
      endcase
      r = (r + m) >> 6; g = (g + m) >> 6; b = (b + m) >> 6;
      if (r > 1020) r = 1020;
      if (g > 1020) g = 1020;
      if (b > 1020) b = 1020;
      return {10'(r), 10'(g), 10'(b)};
   endfunction

   logic [29:0] cpipe [PIPE_LAT];
   always @(posedge CLK) begin
      cpipe[0] <= cnv_model(cnv_h, cnv_s, cnv_v);
      for (int k = 1; k < PIPE_LAT; k++) cpipe[k] <= cpipe[k-1];
   end
   assign {cnv_r, cnv_g, cnv_b} = cpipe[PIPE_LAT-1];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic int first_set(logic [N_REQ-1:0] m);
      for (int i = 0; i < N_REQ; i++) if (m[i]) return i;
      return -1;
   endfunction

   // Monitor, accept tracker and issue-register checker, all sampled on the falling edge.
   initial begin
      logic             chk_cnv;
      logic [H_W-1:0]   nh;
      logic [SV_W-1:0]  ns, nv;
      exp_t             e;
      int               id;
      chk_cnv = 1'b0;
      nh = '0; ns = '0; nv = '0;
      forever begin
         @(negedge CLK);
         if (!RST_N) begin
            chk_cnv  = 1'b0;
            acc_mask = '0;
         end else begin
            if (chk_cnv) begin
               check("cnv_h", cnv_h, nh);
               check("cnv_sv", {cnv_s, cnv_v}, {ns, nv});
            end else begin
               check("cnv_idle_zero", {cnv_h, cnv_s, cnv_v} == '0 ? 1 : 0, 1);
            end
            if (rsp_valid) begin
               if (sb.size() == 0) begin
                  check("rsp_unexpected", 1, 0);
               end else begin
                  e = sb.pop_front();
                  check("rsp_id", rsp_id, e.id);
                  check("rsp_rgb", {rsp_r, rsp_g, rsp_b}, e.rgb);
                  check("rsp_latency", cyc, e.due);
               end
            end
            acc_mask = req_valid & req_ready;
            if (req_valid != '0) check("issue_gap", (req_ready != '0) ? 1 : 0, 1);
            if (acc_mask != '0) begin
               check("grant_onehot", $countones(acc_mask), 1);
               if (exp_gnt.size() == 0) begin
                  check("grant_unexpected", first_set(acc_mask), 32'hFFFF_FFFF);
                  id = first_set(acc_mask);
               end else begin
                  id = exp_gnt.pop_front();
                  check("grant_id", first_set(acc_mask), id);
               end
               sb.push_back('{id: id, rgb: exp_rgb[id], due: cyc + PIPE_LAT + 2});
               chk_cnv = 1'b1;
               nh = dat_h[id]; ns = dat_s[id]; nv = dat_v[id];
            end else begin
               chk_cnv = 1'b0;
            end
         end
      end
   end

   task automatic drive_valid();
      for (int i = 0; i < N_REQ; i++) req_valid[i] = (rem[i] > 0);
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
      for (int i = 0; i < N_REQ; i++) if (acc_mask[i]) rem[i]--;
      drive_valid();
   endtask

   task automatic set_req(input int i, input logic [H_W-1:0] h, input logic [SV_W-1:0] s,
                          input logic [SV_W-1:0] v, input logic [29:0] rgb);
      dat_h[i] = h; dat_s[i] = s; dat_v[i] = v; exp_rgb[i] = rgb;
   endtask

   task automatic drain(input string name);
      int n;
      int pend;
      n = 0;
      pend = 1;
      while (pend != 0 && n < 300) begin
         step();
         n++;
         pend = sb.size() + exp_gnt.size();
         for (int i = 0; i < N_REQ; i++) pend += rem[i];
      end
      check(name, pend, 0);
      repeat (3) step();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      req_valid = '0;
      for (int i = 0; i < N_REQ; i++) begin
         rem[i] = 0;
         set_req(i, '0, '0, '0, '0);
      end
      #3;
      check("rst_ready", req_ready, 0);
      check("rst_cnv", {cnv_h, cnv_s, cnv_v} == '0 ? 1 : 0, 1);
      check("rst_rsp", {rsp_valid, rsp_id, rsp_r, rsp_g, rsp_b}, 0);
      check("rst_busy", busy, 0);
      step();
      step();
      RST_N = 1'b1;

      // All four contending: runs of BURST in order 0,1,2,3,0,...
      set_req(0, '0, '0, 18'h04000, {10'h100, 10'h100, 10'h100});
      set_req(1, '0, '0, 18'h08000, {10'h200, 10'h200, 10'h200});
      set_req(2, '0, '0, 18'h0C000, {10'h300, 10'h300, 10'h300});
      set_req(3, '0, '0, 18'h10000, {10'h3FC, 10'h3FC, 10'h3FC});
      for (int r = 0; r < 8; r++) for (int k = 0; k < 4; k++) exp_gnt.push_back(r % 4);
      for (int i = 0; i < N_REQ; i++) rem[i] = 8;
      drive_valid();
      step();
      check("busy_active", busy, 1);
      drain("drain_burst");
      check("busy_idle", busy, 0);

      // Single saturated red from requester 2.
      set_req(2, '0, ONE_2P16, ONE_2P16, {10'h3FC, 10'h000, 10'h000});
      exp_gnt.push_back(2);
      rem[2] = 1;
      drive_valid();
      drain("drain_red");

      // Mid-grey from requester 0.
      set_req(0, '0, '0, 18'h08000, {10'h200, 10'h200, 10'h200});
      exp_gnt.push_back(0);
      rem[0] = 1;
      drive_valid();
      drain("drain_gray");

      // Requester 1 alone for 10 cycles: re-granted past BURST with no contention.
      set_req(1, '0, '0, 18'h06000, {10'h180, 10'h180, 10'h180});
      for (int k = 0; k < 10; k++) exp_gnt.push_back(1);
      rem[1] = 10;
      drive_valid();
      drain("drain_solo");

      // Hue of exactly 360 degrees is forwarded unchanged and behaves as hue 0.
      set_req(3, HUE_360, ONE_2P16, ONE_2P16, {10'h3FC, 10'h000, 10'h000});
      exp_gnt.push_back(3);
      rem[3] = 1;
      drive_valid();
      drain("drain_h360");

      // Reset with five tags in flight.
      set_req(1, '0, '0, 18'h04000, {10'h100, 10'h100, 10'h100});
      for (int k = 0; k < 5; k++) exp_gnt.push_back(1);
      rem[1] = 5;
      drive_valid();
      for (int n = 0; n < 20 && rem[1] > 0; n++) step();
      check("pre_reset_accepts", rem[1], 0);
      step();
      step();
      #2;
      RST_N = 1'b0;
      #1;
      check("arst_ready", req_ready, 0);
      check("arst_cnv", {cnv_h, cnv_s, cnv_v} == '0 ? 1 : 0, 1);
      check("arst_rsp", {rsp_valid, rsp_id, rsp_r, rsp_g, rsp_b}, 0);
      check("arst_busy", busy, 0);
      sb.delete();
      exp_gnt.delete();
      step();
      step();
      RST_N = 1'b1;
      set_req(0, '0, '0, 18'h02000, {10'h080, 10'h080, 10'h080});
      set_req(2, '0, '0, 18'h08000, {10'h200, 10'h200, 10'h200});
      exp_gnt.push_back(0);
      exp_gnt.push_back(2);
      rem[0] = 1;
      rem[2] = 1;
      drive_valid();
      #1;
      check("post_reset_grant", req_ready, 4'b0001);
      drain("drain_post_reset");
      repeat (2 * PIPE_LAT) step();
      check("final_sb_empty", sb.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
